layer_fifo_bridge: RTL

//  Inter-layer pixel buffer between top_layer3 output and the next layer's input.
//  - Captures each 128-channel pixel (data_out_valid / data_out / vs_next from layer 3) into a small FIFO.
//  - Replays the frame under downstream credit, regenerating a one-cycle verticle_sync ahead of the frame.
//  - Flags overflow and frame-framing errors so that layer 3 never stalls.

---
 rtl/layer_fifo_bridge_pkg.sv | 41 ++++
 rtl/layer_fifo_bridge_if.sv | 28 ++
 rtl/layer_fifo_bridge_fifo.sv | 67 ++++++
 rtl/layer_fifo_bridge.sv | 121 ++++++++++++
 4 files changed

// File: rtl/layer_fifo_bridge_pkg.sv
// Shared types and dimensions for the layer-3 to next-layer pixel bridge.
// The pixel payload is a packed array of signed channels so it moves as one word.
package layer_bridge_pkg;

  localparam int unsigned CHANNEL_NUM    = 128;
  localparam int unsigned DATA_WIDTH     = 16;
  localparam int unsigned FIFO_DEPTH     = 8;
  localparam int unsigned LOG2FIFO_DEPTH = 3;
  localparam int unsigned FM_WIDTH       = 28;
  localparam int unsigned FRAME_PIX      = FM_WIDTH * FM_WIDTH;

  localparam int unsigned PTR_W     = LOG2FIFO_DEPTH;
  localparam int unsigned LEVEL_W   = LOG2FIFO_DEPTH + 1;
  localparam int unsigned PIX_CNT_W = $clog2(FRAME_PIX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    STREAM = 2'd2
  } bridge_state_t;

  typedef logic signed [DATA_WIDTH-1:0] chan_t;
  typedef chan_t [CHANNEL_NUM-1:0]      pixel_t;

  // Occupancy after one cycle of optional push and pop.
  function automatic logic [LEVEL_W-1:0] next_level(
    input logic [LEVEL_W-1:0] level,
    input logic               push,
    input logic               pop
  );
    logic [LEVEL_W-1:0] res;
    res = level;
    if (push && !pop) begin
      res = level + LEVEL_W'(1);
    end else if (pop && !push) begin
      res = level - LEVEL_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/layer_fifo_bridge_if.sv
// Pixel bus between layer 3, the bridge and the next layer.
// master drives the layer-3 side and downstream credit; slave is the bridge.
interface layer_fifo_bridge_if;
  import layer_bridge_pkg::*;

  logic                vs_in;
  logic                data_in_valid;
  pixel_t              data_in;
  logic                out_ready;

  logic                verticle_sync;
  logic                data_out_valid;
  pixel_t              data_out;
  logic [LEVEL_W-1:0]  fifo_level;
  logic                overflow;
  logic                frame_err;

  modport master (
    output vs_in, data_in_valid, data_in, out_ready,
    input  verticle_sync, data_out_valid, data_out, fifo_level, overflow, frame_err
  );

  modport slave (
    input  vs_in, data_in_valid, data_in, out_ready,
    output verticle_sync, data_out_valid, data_out, fifo_level, overflow, frame_err
  );

endinterface

// File: rtl/layer_fifo_bridge_fifo.sv
// Synchronous pixel FIFO with registered occupancy and full/empty flags.
// The caller guarantees no push when full unless it pops in the same cycle.
module bridge_fifo
  import layer_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  pixel_t             wr_data_i,
  input  logic               rd_i,
  output pixel_t             rd_data_c_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LEVEL_W-1:0] level_o
);

  pixel_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  // Pointer, level and flag next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = next_level(level_q, wr_i, rd_i);
    full_d  = (level_d == LEVEL_W'(FIFO_DEPTH));
    empty_d = (level_d == LEVEL_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_c_o = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign level_o     = level_q;

endmodule

// File: rtl/layer_fifo_bridge.sv
// Buffers layer-3 pixels and replays each frame under downstream credit,
// regenerating the frame-start pulse and flagging drops and misframed starts.
module layer_fifo_bridge
  import layer_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  layer_fifo_bridge_if.slave bus
);

  bridge_state_t          state_q, state_d;
  logic [PIX_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   vsync_q, vsync_d;
  logic                   valid_q, valid_d;
  pixel_t                 data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic                   ferr_q, ferr_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LEVEL_W-1:0]     fifo_level;
  pixel_t                 fifo_rd_data_c;

  logic                   rd_c;
  logic                   wr_c;
  logic                   drop_c;

  // Layer 3 never stalls: a full FIFO only accepts if it is also popping.
  assign rd_c   = (state_q == STREAM) && !fifo_empty && bus.out_ready;
  assign wr_c   = bus.data_in_valid && (!fifo_full || rd_c);
  assign drop_c = bus.data_in_valid && fifo_full && !rd_c;

  bridge_fifo u_fifo (
    .clk         (clk),
    .rst         (rstn),
    .wr_i        (wr_c),
    .wr_data_i   (bus.data_in),
    .rd_i        (rd_c),
    .rd_data_c_o (fifo_rd_data_c),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  // Frame sequencing, output staging and sticky error flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vsync_d = 1'b0;
    valid_d = 1'b0;
    data_d  = data_q;
    ovf_d   = ovf_q | drop_c;
    ferr_d  = ferr_q;

    case (state_q)
      IDLE: begin
        if (bus.vs_in) begin
          state_d = SYNC;
          vsync_d = 1'b1;
        end
      end

      SYNC: begin
        cnt_d   = '0;
        state_d = STREAM;
        if (bus.vs_in) begin
          ferr_d = 1'b1;
        end
      end

      STREAM: begin
        if (bus.vs_in) begin
          ferr_d = 1'b1;
        end
        if (rd_c) begin
          valid_d = 1'b1;
          data_d  = fifo_rd_data_c;
          if (cnt_q == PIX_CNT_W'(FRAME_PIX - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + PIX_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vsync_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.verticle_sync  = vsync_q;
  assign bus.data_out_valid = valid_q;
  assign bus.data_out       = data_q;
  assign bus.fifo_level     = fifo_level;
  assign bus.overflow       = ovf_q;
  assign bus.frame_err      = ferr_q;

endmodule
